fb_write_queue: RTL and testbench
=================================

Name: fb_write_queue

Overview:
- Sits directly downstream of the game processor.
- Consumes its plot strobe, x, y and plot_color, and queues pixel writes in a small FIFO.
- Converts (x,y) to a linear 160x120 framebuffer address and drains writes to the VGA framebuffer memory port under a valid/ready handshake.
- Clears the whole screen to a fixed colour after reset or on request.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SCREEN_W, 160, pixels per row.
- SCREEN_H, 120, rows.
- CLEAR_COLOR, 3'b000, colour written by a clear sweep.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- plot  in  1  pixel write request, one pixel per cycle high.
- x  in  8  pixel column.
- y  in  7  pixel row.
- plot_color  in  3  pixel colour.
- clear_req  in  1  single-cycle pulse; start a full-screen clear.
- mem_addr  out  15  framebuffer address = y*SCREEN_W + x.
- mem_data  out  3  framebuffer write colour.
- mem_we  out  1  write valid.
- mem_ready  in  1  framebuffer accepts the write this cycle.
- clearing  out  1  high while a clear sweep is in progress.
- overflow  out  1  sticky; a plot was dropped because the FIFO was full.

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, overflow=0, mem_we=0, mem_addr=0, mem_data=0, clear counter=0, state=CLEAR, clearing=1.
- Reset mid-operation aborts everything; no partial state survives.
- States:
  - CLEAR: mem_we=1, mem_addr=clear counter, mem_data=CLEAR_COLOR.
    - Counter increments on each mem_we&&mem_ready.
    - After the accepted write at address SCREEN_W*SCREEN_H-1 (19199), go to RUN and drop clearing in the next cycle.
  - RUN:
    - FIFO non-empty: mem_we=1 with the head entry's addr/data.
    - Head pops on mem_we&&mem_ready.
    - FIFO empty: mem_we=0.
- Handshake: while mem_we=1 and mem_ready=0, mem_addr and mem_data hold stable. mem_we never deasserts without acceptance, except on reset.
- Enqueue:
  - plot=1 with x<SCREEN_W and y<SCREEN_H pushes {addr,color}.
  - Address computed combinationally as (y<<7)+(y<<5)+x for the default width, generally y*SCREEN_W+x; result is 15 bits.
- Out-of-range plot (x>=SCREEN_W or y>=SCREEN_H): silently discarded; FIFO and overflow unaffected.
- Plots are accepted and queued during CLEAR; they drain only in RUN, so cleared background never overwrites them.
- Full FIFO with plot=1:
  - Accepted if a pop occurs the same cycle (simultaneous push/pop at full is legal).
  - Otherwise dropped and overflow set.
  - overflow clears only on reset.
- Empty FIFO with simultaneous push: entry appears at head next cycle; no same-cycle bypass.
- Latency: plot sampled at edge n into an empty FIFO in RUN -> mem_we=1 with that pixel from cycle n+1.
- Order: writes leave in plot order. Pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
- clear_req:
  - In RUN: enter CLEAR on the next edge after any in-flight head write is accepted (never abandon a presented write). Counter restarts at 0; FIFO contents retained and drained after the sweep.
  - During CLEAR: ignored (no restart).

Optional Feature:
- Macro: FB_WRITE_STATS_EN.
- Defined:
  - Adds outputs pix_written[15:0], pix_dropped[15:0].
  - pix_written counts accepted RUN writes; pix_dropped counts full-FIFO drops plus out-of-range discards.
  - Both saturate at 16'hFFFF and reset to 0.
  - Count increments on the same edge as the event.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, mem_ready=1 constant -> clearing=1; mem_we high 19200 consecutive cycles, mem_addr 0..19199, mem_data=000; then clearing=0, mem_we=0.
- After clear, plot x=10,y=2,color=5 at edge n -> mem_we=1, mem_addr=330, mem_data=5 from cycle n+1; one accepted write.
- mem_ready=0, 5 back-to-back plots (DEPTH=4) -> first 4 queued, 5th dropped, overflow=1. Raise mem_ready -> 4 writes in order, addr/data stable while stalled.
- FIFO full, plot coincident with mem_ready=1 -> push accepted, overflow stays 0. Plot x=160,y=0 -> no write, no overflow.
- clear_req while head write stalled (mem_ready=0) -> head write completes first, then clearing=1 sweep from addr 0; queued pixels written after address 19199.
- Assert reset mid-sweep at addr 500 -> outputs return to reset values immediately; sweep restarts at 0 when reset releases.

Source files
------------

// File: rtl/fb_write_queue.sv
// Pixel write queue between the game processor and the VGA framebuffer port.
// Optional statistics counters are enabled by defining FB_WRITE_STATS_EN.
module fb_write_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SCREEN_W    = 160,
    parameter int unsigned SCREEN_H    = 120,
    parameter logic [2:0]  CLEAR_COLOR = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  plot_color,
    input  logic        clear_req,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        clearing,
    output logic        overflow
`ifdef FB_WRITE_STATS_EN
    ,
    output logic [15:0] pix_written,
    output logic [15:0] pix_dropped
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [14:0]   LAST_ADDR  = 15'(SCREEN_W * SCREEN_H - 1);
    localparam logic [14:0]   ROW_PITCH  = 15'(SCREEN_W);
    localparam logic [8:0]    X_LIMIT    = 9'(SCREEN_W);
    localparam logic [7:0]    Y_LIMIT    = 8'(SCREEN_H);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          started;
    logic          clear_pend;
    logic [14:0]   clear_cnt;

    logic [14:0]   addr_mem [DEPTH];
    logic [2:0]    data_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          empty, full;
    logic          in_range;
    logic [14:0]   plot_addr;
    logic          push, pop, drop_full;
    logic          accept_clear;
    logic          clear_last;
    logic          clear_go;

    always_comb begin
        in_range  = ({1'b0, x} < X_LIMIT) && ({1'b0, y} < Y_LIMIT);
        plot_addr = 15'(y) * ROW_PITCH + 15'(x);
    end

    always_comb begin
        empty        = (count == '0);
        full         = (count == FULL_COUNT);
        accept_clear = (state == CLEAR) && started && mem_ready;
        clear_last   = (clear_cnt == LAST_ADDR);
        pop          = (state == RUN) && !empty && mem_ready;
        // A push into a full FIFO is legal only when the head leaves this cycle.
        push         = plot && in_range && (!full || pop);
        drop_full    = plot && in_range && full && !pop;
        // Clear may only start once no write is being presented unaccepted.
        clear_go     = (clear_req || clear_pend) && (empty || mem_ready);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (accept_clear && clear_last) state_nxt = RUN;
            RUN:     if (clear_go) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        clearing = (state == CLEAR);
        if (state == CLEAR) begin
            mem_we   = started;
            mem_addr = clear_cnt;
            mem_data = CLEAR_COLOR;
        end else if (!empty) begin
            mem_we   = 1'b1;
            mem_addr = addr_mem[rd_ptr];
            mem_data = data_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR;
            started    <= 1'b0;
            clear_pend <= 1'b0;
            clear_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (state_nxt == CLEAR && state == RUN) begin
                clear_pend <= 1'b0;
            end else if (state == RUN && clear_req) begin
                clear_pend <= 1'b1;
            end
            if (state == CLEAR) begin
                if (accept_clear) begin
                    clear_cnt <= clear_last ? '0 : clear_cnt + 15'd1;
                end
            end else begin
                clear_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= plot_addr;
            data_mem[wr_ptr] <= plot_color;
        end
    end

`ifdef FB_WRITE_STATS_EN
    logic drop_any;

    always_comb begin
        drop_any = plot && (!in_range || drop_full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_written <= '0;
            pix_dropped <= '0;
        end else begin
            if (pop && pix_written != '1)      pix_written <= pix_written + 16'd1;
            if (drop_any && pix_dropped != '1) pix_dropped <= pix_dropped + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_write_queue.sv
// Directed self-checking bench for fb_write_queue (default build, stats disabled).
module tb_fb_write_queue;

    logic        clk;
    logic        reset;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  plot_color;
    logic        clear_req;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic        clearing;
    logic        overflow;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    fb_write_queue #(
        .DEPTH      (4),
        .SCREEN_W   (160),
        .SCREEN_H   (120),
        .CLEAR_COLOR(3'b000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .plot      (plot),
        .x         (x),
        .y         (y),
        .plot_color(plot_color),
        .clear_req (clear_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .clearing  (clearing),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks a write being presented: {mem_we, clearing, mem_data, mem_addr}.
    task automatic check_wr(input string tag, input logic cl, input logic [2:0] d, input logic [14:0] a);
        check(tag, {12'd0, mem_we, clearing, mem_data, mem_addr}, {12'd0, 1'b1, cl, d, a});
    endtask

    task automatic do_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        plot = 1'b1; x = px; y = py; plot_color = pc;
        @(negedge clk);
        plot = 1'b0;
    endtask

    // Expects a clear sweep presenting addresses 0..n-1 at mem_ready=1; optional clear_req pulse.
    task automatic sweep(input int unsigned n, input int pulse_at);
        for (int unsigned i = 0; i < n; i++) begin
            check_wr("sweep", 1'b1, 3'b000, 15'(i));
            clear_req = (int'(i) == pulse_at);
            @(negedge clk);
        end
        clear_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0; plot = 1'b0; x = '0; y = '0; plot_color = '0;
        clear_req = 1'b0; mem_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_clearing", 32'(clearing), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Power-up clear sweep
        reset = 1'b1;
        @(negedge clk);
        sweep(19200, -1);
        check("post_clear_clearing", 32'(clearing), 32'd0);
        check("post_clear_we", 32'(mem_we), 32'd0);

        // Single plot, n+1 latency
        do_plot(8'd10, 7'd2, 3'd5);
        check_wr("single_plot", 1'b0, 3'd5, 15'd330);
        @(negedge clk);
        check("single_done", 32'(mem_we), 32'd0);

        // Fill to full while stalled, then push coincident with a pop
        mem_ready = 1'b0;
        do_plot(8'd1, 7'd1, 3'd1);
        do_plot(8'd2, 7'd1, 3'd2);
        do_plot(8'd3, 7'd1, 3'd3);
        do_plot(8'd4, 7'd1, 3'd4);
        check_wr("full_head", 1'b0, 3'd1, 15'd161);
        check("full_no_ovf", 32'(overflow), 32'd0);
        mem_ready = 1'b1;
        do_plot(8'd5, 7'd1, 3'd5);
        check("coinc_ovf", 32'(overflow), 32'd0);
        check_wr("coinc_q1", 1'b0, 3'd2, 15'd162);
        @(negedge clk);
        check_wr("coinc_q2", 1'b0, 3'd3, 15'd163);
        @(negedge clk);
        check_wr("coinc_q3", 1'b0, 3'd4, 15'd164);
        @(negedge clk);
        check_wr("coinc_q4", 1'b0, 3'd5, 15'd165);
        @(negedge clk);
        check("coinc_empty", 32'(mem_we), 32'd0);

        // Out-of-range plots are discarded silently
        do_plot(8'd160, 7'd0, 3'd7);
        check("oor_x_we", 32'(mem_we), 32'd0);
        do_plot(8'd0, 7'd120, 3'd7);
        check("oor_y_we", 32'(mem_we), 32'd0);
        check("oor_ovf", 32'(overflow), 32'd0);

        // Five plots while stalled: fifth is dropped
        mem_ready = 1'b0;
        do_plot(8'd0, 7'd0, 3'd1);
        check_wr("stall_a", 1'b0, 3'd1, 15'd0);
        do_plot(8'd159, 7'd0, 3'd2);
        check_wr("stall_b", 1'b0, 3'd1, 15'd0);
        do_plot(8'd0, 7'd1, 3'd3);
        do_plot(8'd159, 7'd119, 3'd4);
        check("ovf_before_drop", 32'(overflow), 32'd0);
        do_plot(8'd7, 7'd7, 3'd6);
        check("ovf_after_drop", 32'(overflow), 32'd1);
        @(negedge clk);
        check_wr("stall_hold", 1'b0, 3'd1, 15'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        check_wr("drain_1", 1'b0, 3'd2, 15'd159);
        @(negedge clk);
        check_wr("drain_2", 1'b0, 3'd3, 15'd160);
        @(negedge clk);
        check_wr("drain_3", 1'b0, 3'd4, 15'd19199);
        @(negedge clk);
        check("drain_empty", 32'(mem_we), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // clear_req while head write is stalled
        mem_ready = 1'b0;
        do_plot(8'd20, 7'd3, 3'd6);
        do_plot(8'd21, 7'd3, 3'd7);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        check_wr("clr_hold_1", 1'b0, 3'd6, 15'd500);
        @(negedge clk);
        check_wr("clr_hold_2", 1'b0, 3'd6, 15'd500);
        mem_ready = 1'b1;
        @(negedge clk);
        // clear_req pulsed mid-sweep must not restart it
        sweep(19200, 100);
        check_wr("after_sweep_q", 1'b0, 3'd7, 15'd501);
        @(negedge clk);
        check("after_sweep_empty", 32'(mem_we), 32'd0);

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        sweep(500, -1);
        check_wr("mid_sweep_500", 1'b1, 3'd0, 15'd500);
        reset = 1'b0;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_clearing", 32'(clearing), 32'd1);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sweep(10, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
